// File: rtl/aes_pkg.sv
// Shared types and sizing for the inverse-AES SPI front end.
package aes_pkg;

  localparam int unsigned BLOCK_BITS  = 128;
  localparam int unsigned FRAME_BITS  = 256;
  localparam int unsigned MASK_CYCLES = 4;
  localparam int unsigned CNT_W       = 9;
  localparam int unsigned MASK_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_IN,
    WAIT_CORE,
    SHIFT_OUT
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus rise/fall detect against a third copy.
module sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_d};
    end
  end

  assign o_level = r_sync[1];
  assign o_rise  = r_sync[1] & ~r_sync[2];
  assign o_fall  = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/invaes_spi_frontend.sv
// SPI front end for an inverse-AES core: shifts in key+ciphertext, runs the core,
// and shifts the plaintext back out to the Pi.
module invaes_spi_frontend
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  sdi,
  input  logic                  load,
  output logic                  sdo,
  output logic                  ce,
  output logic [BLOCK_BITS-1:0] key,
  output logic [BLOCK_BITS-1:0] cyphertext,
  input  logic                  core_done,
  input  logic [BLOCK_BITS-1:0] plaintext,
  output logic                  done,
  output logic                  frame_err
);

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_sdi_level, w_sdi_rise, w_sdi_fall;
  logic w_load_level, w_load_rise, w_load_fall;
  logic w_unused_sync;

  sync_edge u_sync_sck (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (sck),
    .o_level (w_sck_level),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  sync_edge u_sync_sdi (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (sdi),
    .o_level (w_sdi_level),
    .o_rise  (w_sdi_rise),
    .o_fall  (w_sdi_fall)
  );

  sync_edge u_sync_load (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (load),
    .o_level (w_load_level),
    .o_rise  (w_load_rise),
    .o_fall  (w_load_fall)
  );

  // Only the data level of sdi and the edges of sck/load drive the FSM.
  assign w_unused_sync = ^{w_sck_level, w_sdi_rise, w_sdi_fall, w_load_level};

  state_e                r_state, w_state_d;
  logic [CNT_W-1:0]      r_cnt, w_cnt_d;
  logic [MASK_W-1:0]     r_mask, w_mask_d;
  logic [FRAME_BITS-1:0] r_shift, w_shift_d;
  logic [BLOCK_BITS-1:0] r_out, w_out_d;
  logic                  r_done, w_done_d;
  logic                  r_ferr, w_ferr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_shift <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_mask  <= w_mask_d;
      r_shift <= w_shift_d;
      r_out   <= w_out_d;
      r_done  <= w_done_d;
      r_ferr  <= w_ferr_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_mask_d  = r_mask;
    w_shift_d = r_shift;
    w_out_d   = r_out;
    w_done_d  = r_done;
    w_ferr_d  = r_ferr;
    // A load rise restarts the frame from any state and hides any sck edge this cycle.
    if (w_load_rise) begin
      w_state_d = SHIFT_IN;
      w_cnt_d   = '0;
      w_ferr_d  = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
        end
        SHIFT_IN: begin
          if (w_load_fall) begin
            if (r_cnt == CNT_W'(FRAME_BITS)) begin
              w_state_d = WAIT_CORE;
              w_mask_d  = '0;
            end else begin
              w_state_d = IDLE;
              w_ferr_d  = 1'b1;
            end
          end else if (w_sck_rise) begin
            w_shift_d = {r_shift[FRAME_BITS-2:0], w_sdi_level};
            if (r_cnt != CNT_W'(FRAME_BITS)) w_cnt_d = r_cnt + 1'b1;
          end
        end
        WAIT_CORE: begin
          if (r_mask != MASK_W'(MASK_CYCLES)) begin
            w_mask_d = r_mask + 1'b1;
          end else if (core_done) begin
            w_out_d   = plaintext;
            w_done_d  = 1'b1;
            w_cnt_d   = '0;
            w_state_d = SHIFT_OUT;
          end
        end
        SHIFT_OUT: begin
          if (w_sck_fall) begin
            w_out_d = {r_out[BLOCK_BITS-2:0], 1'b0};
            if (r_cnt == CNT_W'(BLOCK_BITS - 1)) w_state_d = IDLE;
            else                                 w_cnt_d   = r_cnt + 1'b1;
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  assign ce         = (r_state == IDLE) || (r_state == SHIFT_IN);
  assign sdo        = (r_state == SHIFT_OUT) & r_out[BLOCK_BITS-1];
  assign key        = r_shift[FRAME_BITS-1:BLOCK_BITS];
  assign cyphertext = r_shift[BLOCK_BITS-1:0];
  assign done       = r_done;
  assign frame_err  = r_ferr;

endmodule

// File: tb/tb_invaes_spi_frontend.sv
// Directed bench for invaes_spi_frontend with a stand-in core and a plaintext scoreboard.
module tb_invaes_spi_frontend;

  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;

  logic         clk, reset, sck, sdi, load;
  logic         sdo, ce, done, frame_err;
  logic [127:0] key, cyphertext, plaintext;
  logic         core_done, core_auto, man_done, auto_done;

  int n_checks = 0;
  int n_err    = 0;
  int cyc;
  logic [127:0] exp_q[$];

  assign core_done = core_auto ? auto_done : man_done;

  invaes_spi_frontend dut (
    .clk        (clk),
    .reset      (reset),
    .sck        (sck),
    .sdi        (sdi),
    .load       (load),
    .sdo        (sdo),
    .ce         (ce),
    .key        (key),
    .cyphertext (cyphertext),
    .core_done  (core_done),
    .plaintext  (plaintext),
    .done       (done),
    .frame_err  (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in core: the FIPS-197 pair decrypts to its known plaintext, anything else to key^ct.
  function automatic logic [127:0] pt_of(input logic [127:0] k, input logic [127:0] c);
    return (k == FIPS_K && c == FIPS_C) ? FIPS_P : (k ^ c);
  endfunction

  initial begin
    auto_done = 1'b0;
    plaintext = '0;
    cyc       = 0;
    forever begin
      @(negedge clk);
      if (ce) begin
        cyc       = 0;
        auto_done = 1'b0;
      end else begin
        if (cyc < 1000) cyc++;
        plaintext = pt_of(key, cyphertext);
        auto_done = (cyc >= 6);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [259:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      tick(6);
      sck = 1'b1;
      tick(6);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [259:0] v, input int n);
    load = 1'b1;
    tick(8);
    send_bits(v, n);
    tick(8);
    load = 1'b0;
  endtask

  task automatic wait_ce_low(input string tag);
    int c = 0;
    while (ce && c < 50) begin
      tick(1);
      c++;
    end
    check(tag, {255'd0, (!ce && c <= 4)}, 256'd1);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!done && c < 300) begin
      tick(1);
      c++;
    end
    check(tag, {255'd0, done}, 256'd1);
  endtask

  task automatic read_out(input int n, output logic [127:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      tick(6);
      got[127-i] = sdo;
      sck = 1'b1;
      tick(6);
      sck = 1'b0;
    end
    tick(6);
  endtask

  task automatic full_round(input string tag, input logic [127:0] k, input logic [127:0] c);
    logic [127:0] got;
    exp_q.push_back(pt_of(k, c));
    frame({4'h0, k, c}, 256);
    wait_ce_low({tag, "_ce_fall"});
    check({tag, "_key"}, {128'd0, key}, {128'd0, k});
    check({tag, "_ct"}, {128'd0, cyphertext}, {128'd0, c});
    wait_done({tag, "_done"});
    read_out(128, got);
    check({tag, "_pt"}, {128'd0, got}, {128'd0, exp_q.pop_front()});
  endtask

  // Core holds done high across ce fall, drops it at cycle drop_k, raises it at rise_k.
  task automatic stale_round(input string tag, input int drop_k, input int rise_k);
    logic [127:0] k, c, got;
    k = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(pt_of(k, c));
    core_auto = 1'b0;
    man_done  = 1'b1;
    frame({4'h0, k, c}, 256);
    wait_ce_low({tag, "_ce_fall"});
    for (int i = 1; i <= rise_k; i++) begin
      tick(1);
      check({tag, "_no_capture"}, {255'd0, done}, 256'd0);
      if (i == drop_k) man_done = 1'b0;
      if (i == rise_k) man_done = 1'b1;
    end
    tick(1);
    check({tag, "_capture"}, {255'd0, done}, 256'd1);
    read_out(128, got);
    check({tag, "_pt"}, {128'd0, got}, {128'd0, exp_q.pop_front()});
    man_done  = 1'b0;
    core_auto = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce"}, {255'd0, ce}, 256'd1);
    check({tag, "_done"}, {255'd0, done}, 256'd0);
    check({tag, "_ferr"}, {255'd0, frame_err}, 256'd0);
    check({tag, "_sdo"}, {255'd0, sdo}, 256'd0);
    check({tag, "_key"}, {128'd0, key}, 256'd0);
    check({tag, "_ct"}, {128'd0, cyphertext}, 256'd0);
  endtask

  initial begin
    logic [127:0] k, c, got, exp;
    reset     = 1'b1;
    sck       = 1'b0;
    sdi       = 1'b0;
    load      = 1'b0;
    core_auto = 1'b1;
    man_done  = 1'b0;
    tick(4);
    reset = 1'b0;
    tick(2);
    check_reset_outputs("reset");

    full_round("fips", FIPS_K, FIPS_C);
    check("fips_done_held", {255'd0, done}, 256'd1);
    check("fips_idle_ce", {255'd0, ce}, 256'd1);
    check("fips_idle_sdo", {255'd0, sdo}, 256'd0);

    frame({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           4'h5}, 255);
    tick(4);
    check("short_ferr", {255'd0, frame_err}, 256'd1);
    check("short_ce", {255'd0, ce}, 256'd1);
    check("short_done", {255'd0, done}, 256'd0);

    k = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(pt_of(k, c));
    frame({4'hB, k, c}, 260);
    wait_ce_low("long_ce_fall");
    check("long_key", {128'd0, key}, {128'd0, k});
    check("long_ct", {128'd0, cyphertext}, {128'd0, c});
    check("long_ferr", {255'd0, frame_err}, 256'd0);
    wait_done("long_done");
    read_out(128, got);
    check("long_pt", {128'd0, got}, {128'd0, exp_q.pop_front()});

    stale_round("stale", 2, 10);
    stale_round("stale_edge", 4, 6);

    k = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(pt_of(k, c));
    frame({4'h0, k, c}, 256);
    wait_ce_low("abort_ce_fall");
    wait_done("abort_done");
    read_out(40, got);
    exp = exp_q.pop_front();
    check("abort_partial", {216'd0, got[127:88]}, {216'd0, exp[127:88]});
    load = 1'b1;
    tick(6);
    check("abort_done_clr", {255'd0, done}, 256'd0);
    check("abort_ce", {255'd0, ce}, 256'd1);
    check("abort_sdo", {255'd0, sdo}, 256'd0);
    k = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(pt_of(k, c));
    tick(2);
    send_bits({4'h0, k, c}, 256);
    tick(8);
    load = 1'b0;
    wait_ce_low("after_abort_ce_fall");
    check("after_abort_key", {128'd0, key}, {128'd0, k});
    wait_done("after_abort_done");
    read_out(128, got);
    check("after_abort_pt", {128'd0, got}, {128'd0, exp_q.pop_front()});

    k = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    load = 1'b1;
    tick(8);
    send_bits({4'h0, k, c} >> 156, 100);
    reset = 1'b1;
    load  = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    reset = 1'b0;
    tick(2);
    full_round("post_reset", {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
